// File: rtl/flash_cmd_seq.sv
// flash_cmd_seq: splits one multi-unit host flash command into single controller transactions; ports: host cmd/wdata/rd_out, controller req/addr/data/ack
module flash_cmd_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter logic [23:0] SECTOR_INC = 24'h010000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [23:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic        wdata_valid,
  input  logic [7:0]  wdata,
  output logic        wdata_ready,
  output logic        rd_out_valid,
  output logic [31:0] rd_out_data,
  input  logic        rd_out_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        rd_req,
  output logic        pp_req,
  output logic        se_req,
  output logic [23:0] rd_addr,
  output logic [23:0] wr_addr,
  output logic [23:0] se_addr,
  output logic [7:0]  data_into_flash,
  input  logic        flash_ack,
  input  logic [31:0] rdata
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] op;
  logic [23:0] cur_addr;
  logic [7:0] remain;
  logic req, go, ack, push, pop;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  assign ack = state == WAIT_ACK && flash_ack;
  assign push = ack && op == 2'd0;
  assign pop = rd_out_ready && count != '0;
  assign wdata_ready = state == ISSUE && op == 2'd1 && wdata_valid;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign err = done && op == 2'd3;
  assign rd_req = req && op == 2'd0;
  assign pp_req = req && op == 2'd1;
  assign se_req = req && op == 2'd2;
  assign rd_addr = cur_addr;
  assign wr_addr = cur_addr;
  assign se_addr = cur_addr;
  assign rd_out_valid = count != '0;
  assign rd_out_data = rd_out_valid ? mem[rptr] : '0;
  always_comb begin
    state_nx = state;
    go = 1'b0;
    case (state)
      IDLE: if (cmd_valid) state_nx = (cmd_op == 2'd3 || cmd_len == '0) ? DONE : ISSUE;
      ISSUE: begin
        // read credit uses the registered count only; a same-cycle pop is not counted
        go = op == 2'd0 ? count < CW'(FIFO_DEPTH) : op == 2'd1 ? wdata_valid : 1'b1;
        if (go) state_nx = WAIT_ACK;
      end
      WAIT_ACK: if (flash_ack) state_nx = remain == 8'd1 ? DONE : ISSUE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      op <= '0;
      cur_addr <= '0;
      remain <= '0;
      req <= 1'b0;
      data_into_flash <= '0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cmd_valid) begin
        op <= cmd_op;
        cur_addr <= cmd_addr;
        remain <= cmd_len;
      end
      if (go) req <= 1'b1;
      if (wdata_ready) data_into_flash <= wdata;
      if (ack) begin
        req <= 1'b0;
        remain <= remain - 8'd1;
        cur_addr <= cur_addr + (op == 2'd0 ? 24'd4 : op == 2'd1 ? 24'd1 : SECTOR_INC);
      end
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= rdata;
endmodule

// File: tb/tb_flash_cmd_seq.sv
// tb_flash_cmd_seq: randomized self-checking bench for flash_cmd_seq against a transaction-level model
module tb_flash_cmd_seq;
  logic clk = 1'b0, reset_n;
  logic cmd_valid, cmd_ready, wdata_valid, wdata_ready, rd_out_valid, rd_out_ready;
  logic busy, done, err, rd_req, pp_req, se_req, flash_ack;
  logic [1:0] cmd_op;
  logic [23:0] cmd_addr, rd_addr, wr_addr, se_addr;
  logic [7:0] cmd_len, wdata, data_into_flash;
  logic [31:0] rd_out_data, rdata;
  int n_chk = 0, n_pass = 0;
  int t = 0, n_exp = 0, k = 0, gap = 0, ack_limit = 1000, cyc = 0, ack_cyc = 0;
  logic [1:0] e_op = 2'd0;
  logic [23:0] e_base = '0;
  logic [7:0] bytes [256];
  logic [31:0] exp_fifo [$];
  bit host_en = 1'b1, pop_one = 1'b0, wd_en = 1'b0;

  flash_cmd_seq #(.FIFO_DEPTH(4), .SECTOR_INC(24'h010000)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .rd_out_valid(rd_out_valid), .rd_out_data(rd_out_data), .rd_out_ready(rd_out_ready),
    .busy(busy), .done(done), .err(err), .rd_req(rd_req), .pp_req(pp_req), .se_req(se_req),
    .rd_addr(rd_addr), .wr_addr(wr_addr), .se_addr(se_addr),
    .data_into_flash(data_into_flash), .flash_ack(flash_ack), .rdata(rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [23:0] step(input logic [1:0] o);
    return o == 2'd0 ? 24'd4 : o == 2'd1 ? 24'd1 : 24'h010000;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] o);
    return o == 2'd0 ? 3'b100 : o == 2'd1 ? 3'b010 : o == 2'd2 ? 3'b001 : 3'b000;
  endfunction

  initial begin
    logic [23:0] a;
    flash_ack = 1'b0;
    rdata = '0;
    forever begin
      @(negedge clk);
      if (reset_n && (rd_req | pp_req | se_req) && t < ack_limit) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        a = e_base + 24'(t) * step(e_op);
        check("req_onehot", {29'd0, rd_req, pp_req, se_req}, {29'd0, onehot(e_op)});
        check("txn_in_range", 32'(t < n_exp), 1);
        check("addr", e_op == 2'd0 ? rd_addr : e_op == 2'd1 ? wr_addr : se_addr, a);
        if (e_op == 2'd1) check("pp_byte", data_into_flash, bytes[t[7:0]]);
        rdata = $urandom;
        if (e_op == 2'd0) exp_fifo.push_back(rdata);
        flash_ack = 1'b1;
        ack_cyc = cyc;
        t++;
        @(negedge clk);
        flash_ack = 1'b0;
        check("req_drop", 32'(rd_req | pp_req | se_req), 0);
      end
    end
  end

  initial begin
    rd_out_ready = 1'b0;
    forever begin
      @(negedge clk);
      rd_out_ready = host_en ? 1'($urandom % 2) : pop_one;
      pop_one = 1'b0;
      if (rd_out_ready && rd_out_valid) begin
        if (exp_fifo.size() == 0) check("fifo_extra", 32'(rd_out_valid), 0);
        else check("rd_word", rd_out_data, exp_fifo.pop_front());
      end
    end
  end

  initial begin
    bit exp_wd;
    wdata_valid = 1'b0;
    wdata = '0;
    forever begin
      @(negedge clk);
      exp_wd = wd_en && k < n_exp && gap == 0;
      if (wd_en && k < n_exp) begin
        wdata_valid = gap == 0;
        if (gap > 0) gap--;
        else wdata = bytes[k[7:0]];
      end else begin
        wdata_valid = 1'($urandom % 2);
        wdata = 8'($urandom);
      end
      #1;
      if (exp_wd) begin
        if (wdata_ready) begin
          k++;
          gap = $urandom_range(0, 5);
        end
      end else if (wdata_valid) check("wd_stray", 32'(wdata_ready), 0);
    end
  end

  task automatic run_cmd(input logic [1:0] o, input logic [23:0] ad, input logic [7:0] ln);
    bit seen = 1'b0;
    e_op = o;
    e_base = ad;
    n_exp = o == 2'd3 ? 0 : int'(ln);
    t = 0;
    k = 0;
    gap = 3;
    for (int i = 0; i < 256; i++) bytes[i] = 8'($urandom);
    wd_en = o == 2'd1;
    @(negedge clk);
    check("ready_idle", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op = o;
    cmd_addr = ad;
    cmd_len = ln;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        cmd_valid = 1'b0;
        check("err", 32'(err), 32'(o == 2'd3));
        check("txns", t, n_exp);
        if (n_exp > 0) check("done_lat", cyc, ack_cyc + 1);
      end else begin
        cmd_valid = 1'($urandom % 2);
        cmd_op = 2'($urandom);
        cmd_addr = 24'($urandom);
        cmd_len = 8'($urandom);
      end
    end
    cmd_valid = 1'b0;
    check("done_seen", 32'(seen), 1);
    @(negedge clk);
    check("done_pulse", 32'(done), 0);
    check("ready_back", 32'(cmd_ready), 1);
    wd_en = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 500 && (exp_fifo.size() != 0 || rd_out_valid); c++) @(negedge clk);
    check("drained", 32'(rd_out_valid), 0);
    check("drain_model", exp_fifo.size(), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_addr = '0;
    cmd_len = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done_err", {30'd0, done, err}, 0);
    check("rst_wdata_ready", 32'(wdata_ready), 0);
    check("rst_reqs", {29'd0, rd_req, pp_req, se_req}, 0);
    check("rst_addrs", 32'(rd_addr | wr_addr | se_addr), 0);
    check("rst_dif", 32'(data_into_flash), 0);
    check("rst_rd_valid", 32'(rd_out_valid), 0);
    check("rst_rd_data", rd_out_data, 0);
    reset_n = 1'b1;
    run_cmd(2'd0, 24'h000100, 8'd3);
    run_cmd(2'd1, 24'h00FFFF, 8'd2);
    run_cmd(2'd2, 24'hFF0000, 8'd2);
    run_cmd(2'd3, 24'h123456, 8'd5);
    run_cmd(2'd0, 24'h000200, 8'd0);
    run_cmd(2'd0, 24'hFFFFF8, 8'd3);
    drain();
    host_en = 1'b0;
    fork
      run_cmd(2'd0, 24'h000400, 8'd6);
      begin
        for (int c = 0; c < 500 && t < 4; c++) @(negedge clk);
        repeat (10) @(negedge clk);
        check("stall_txns", t, 4);
        check("stall_req", 32'(rd_req), 0);
        check("stall_busy", 32'(busy), 1);
        check("stall_full", 32'(rd_out_valid), 1);
        #2 pop_one = 1'b1;
        repeat (12) @(negedge clk);
        check("one_more", t, 5);
        check("stall_req2", 32'(rd_req), 0);
        host_en = 1'b1;
      end
    join
    drain();
    ack_limit = 1;
    e_op = 2'd0;
    e_base = 24'h000800;
    n_exp = 4;
    t = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 2'd0;
    cmd_addr = 24'h000800;
    cmd_len = 8'd4;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 200 && !(t == 1 && rd_req); c++) @(negedge clk);
    check("rst_pre_req", 32'(rd_req), 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_req", 32'(rd_req), 0);
    check("rst_mid_fifo", 32'(rd_out_valid), 0);
    check("rst_mid_ready", 32'(cmd_ready), 1);
    check("rst_mid_busy", 32'(busy), 0);
    exp_fifo.delete();
    @(negedge clk);
    reset_n = 1'b1;
    ack_limit = 1000;
    run_cmd(2'd0, 24'h000900, 8'd1);
    repeat (30) run_cmd(2'($urandom), 24'($urandom), 8'($urandom_range(0, 9)));
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
